fpga_status_wr: RTL and testbench
=================================

FPGA_STATUS_WR -- requirements
Module: fpga_status_wr

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 10'h100: first shared-RAM word address of the status frame.
REQ-002 SHALL have parameter NWORDS, default 16: frame length in words, consisting of 1 counter + 14 data + 1 checksum.
REQ-003 SHALL have parameter INT_WIDTH, default 20: DSP interrupt low time in clk_100M cycles.
REQ-004 SHALL have port clk_100M, input, 1: sole clock; one clock domain throughout.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to upload a status frame (control-period tick).
REQ-007 SHALL have port stat_data, input, 224: 14 status words; word k = stat_data[16k+15:16k].
REQ-008 SHALL have port addr_w, output, 10: shared-RAM write address.
REQ-009 SHALL have port ram_din, output, 16: shared-RAM write data.
REQ-010 SHALL have port ram_we, output, 1: shared-RAM write enable, high for one word per cycle.
REQ-011 SHALL have port fpga_w, output, 1: "FPGA writing" flag to DSP, high while frame words are being written.
REQ-012 SHALL have port XINT_FPGA, output, 1: active-low interrupt to DSP.
REQ-013 SHALL have port busy, output, 1: frame in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at frame completion.
REQ-015 SHALL have port ovr, output, 1: one-cycle pulse when start is rejected.
REQ-016 SHALL have port frame_cnt, output, 16: number of completed frames.

Function
REQ-017 SHALL use states IDLE, WRITE, IRQ. Transitions: IDLE->WRITE on start; WRITE->IRQ after word NWORDS-1; IRQ->IDLE after INT_WIDTH cycles.
REQ-018 SHALL, on the edge sampling start in IDLE: snapshot stat_data and frame_cnt, clear the word index, and set busy=1 and fpga_w=1.
REQ-019 SHALL, in WRITE, assert ram_we for exactly NWORDS consecutive cycles, the first being the cycle after the start cycle, with addr_w=BASE_ADDR+i for i=0..NWORDS-1.
REQ-020 SHALL write word 0 = snapshotted frame_cnt, words 1..14 = snapshot words 0..13, and word 15 = ~(16-bit wrapping sum of words 0..14).
REQ-021 SHALL compute the checksum with a running accumulator; no adder tree over stat_data.
REQ-022 SHALL drop fpga_w and ram_we to 0 in the cycle after the last write, and hold XINT_FPGA=0 for exactly INT_WIDTH cycles starting in that same cycle.
REQ-023 SHALL, in the cycle XINT_FPGA returns to 1: pulse done, drop busy, and increment frame_cnt modulo 2^16 (0xFFFF -> 0x0000).
REQ-024 SHALL treat start while busy=1 (including the last IRQ cycle) as follows: ignore it, pulse ovr for one cycle, and leave the frame in progress undisturbed.
REQ-025 SHALL ignore stat_data changes after the snapshot for the rest of that frame.
REQ-026 SHALL hold addr_w at BASE_ADDR and ram_din at 0 whenever ram_we=0.
REQ-027 SHALL allow start in the cycle after done to begin a new frame normally; the minimum frame-to-frame period is NWORDS+INT_WIDTH+1 cycles.

Reset
REQ-028 SHALL, on reset_n=0, immediately (asynchronously) force: state IDLE, addr_w=BASE_ADDR, ram_din=0, ram_we=0, fpga_w=0, XINT_FPGA=1, busy=0, done=0, ovr=0, frame_cnt=0.
REQ-029 SHALL, on reset mid-frame, abandon the frame with no further writes, no interrupt and no done pulse; the first start after release SHALL produce a complete frame with counter word 0.

Structure
REQ-030 SHALL place BASE_ADDR, NWORDS, INT_WIDTH defaults, the state encoding and the checksum word offset in a shared package used by this block and the DSP-parameter read path.
REQ-031 SHALL split out one sub-module, int_pulse_gen, a counter-based INT_WIDTH low-pulse generator with busy indication; everything else stays in fpga_status_wr.

Verification
REQ-032 SHALL verify: reset, then start with all 14 data words = 0x0001 -> 16 writes at 0x100..0x10F, word0=0x0000, word15=0xFFF1, XINT_FPGA low for 20 cycles, done, frame_cnt=1.
REQ-033 SHALL verify: start, then stat_data changed in the write cycle for 0x102 -> RAM holds the pre-start values.
REQ-034 SHALL verify: a second start 5 cycles after the first and another in the final IRQ cycle -> two ovr pulses, exactly one frame written, frame_cnt=1.
REQ-035 SHALL verify: frame_cnt preloaded to 0xFFFF via 65535 frames (or a force) -> counter word 0xFFFF written, frame_cnt wraps to 0x0000.
REQ-036 SHALL verify: reset_n low during the write to 0x107 -> ram_we=0 at once, XINT_FPGA stays 1, no done; the next start writes counter word 0x0000.
REQ-037 SHALL verify: start in the cycle after done -> the new frame's first write occurs on the next cycle and no ovr pulse is generated.

Source files
------------

// File: rtl/fpga_status_wr_pkg.sv
// Shared constants and types for the FPGA<->DSP shared-RAM paths
// (status-frame upload and DSP-parameter read).
package fpga_status_wr_pkg;

  // Default frame placement and timing
  localparam logic [9:0]  BASE_ADDR_DEF = 10'h100;
  localparam int unsigned NWORDS_DEF    = 16;
  localparam int unsigned INT_WIDTH_DEF = 20;

  // Frame layout: counter word, status words, checksum word
  localparam int unsigned NDATA       = 14;
  localparam int unsigned STAT_W      = 16 * NDATA;
  localparam int unsigned CSUM_OFFSET = NWORDS_DEF - 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StIrq
  } state_e;

  // Checksum sits in the last word of a frame of nwords words
  function automatic int unsigned csum_offset(input int unsigned nwords);
    return nwords - 1;
  endfunction

endpackage

// File: rtl/fpga_status_wr_int_pulse_gen.sv
// Counter-based active-low interrupt pulse: INT_WIDTH cycles low per trigger.
module int_pulse_gen #(
  parameter int unsigned INT_WIDTH = 20
) (
  input  logic clk_100M,
  input  logic reset_n,
  input  logic trig,
  output logic int_n,
  output logic busy,
  output logic fin
);

  localparam int unsigned CntW = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;

  logic [CntW-1:0] cnt_q;

  // Load the down-counter on trigger, release int_n after it reaches zero
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      int_n <= 1'b1;
      cnt_q <= '0;
    end else if (trig && int_n) begin
      int_n <= 1'b0;
      cnt_q <= CntW'(INT_WIDTH - 1);
    end else if (!int_n) begin
      if (cnt_q == '0) begin
        int_n <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy = ~int_n;
  // High during the final low cycle; int_n returns high on the next edge
  assign fin  = ~int_n & (cnt_q == '0);

endmodule

// File: rtl/fpga_status_wr.sv
// Uploads a status frame (counter, 14 status words, inverted checksum) into
// shared RAM, then interrupts the DSP with an active-low pulse.
module fpga_status_wr
  import fpga_status_wr_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned NWORDS    = NWORDS_DEF,
  parameter int unsigned INT_WIDTH = INT_WIDTH_DEF
) (
  input  logic              clk_100M,
  input  logic              reset_n,
  input  logic              start,
  input  logic [STAT_W-1:0] stat_data,
  output logic [9:0]        addr_w,
  output logic [15:0]       ram_din,
  output logic              ram_we,
  output logic              fpga_w,
  output logic              XINT_FPGA,
  output logic              busy,
  output logic              done,
  output logic              ovr,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned     IdxW    = $clog2(NWORDS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(csum_offset(NWORDS));
  localparam logic [IdxW-1:0] EndIdx  = IdxW'(NWORDS);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;   // index of the next word to present
  logic [STAT_W-1:0] snap_q;  // snapshot, shifted down one word per write
  logic [15:0]       acc_q;   // running checksum of words already written
  logic              int_trig;
  logic              int_busy;
  logic              int_fin;

  // Fire the interrupt on the edge that ends the write phase
  assign int_trig = (state_q == StWrite) && (idx_q == EndIdx) && !int_busy;

  int_pulse_gen #(
    .INT_WIDTH (INT_WIDTH)
  ) u_int_pulse_gen (
    .clk_100M (clk_100M),
    .reset_n  (reset_n),
    .trig     (int_trig),
    .int_n    (XINT_FPGA),
    .busy     (int_busy),
    .fin      (int_fin)
  );

  // Frame sequencer with registered RAM-side and status outputs
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      snap_q    <= '0;
      acc_q     <= '0;
      addr_w    <= BASE_ADDR;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      fpga_w    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      ovr  <= start & busy;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Word 0 (frame counter) goes out on the very next cycle
            state_q <= StWrite;
            snap_q  <= stat_data;
            idx_q   <= IdxW'(1);
            acc_q   <= frame_cnt;
            addr_w  <= BASE_ADDR;
            ram_din <= frame_cnt;
            ram_we  <= 1'b1;
            fpga_w  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StWrite: begin
          if (idx_q == EndIdx) begin
            state_q <= StIrq;
            addr_w  <= BASE_ADDR;
            ram_din <= '0;
            ram_we  <= 1'b0;
            fpga_w  <= 1'b0;
          end else begin
            addr_w <= BASE_ADDR + 10'(idx_q);
            idx_q  <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              ram_din <= ~acc_q;
            end else begin
              ram_din <= snap_q[15:0];
              acc_q   <= acc_q + snap_q[15:0];
              snap_q  <= snap_q >> 16;
            end
          end
        end
        StIrq: begin
          if (int_fin) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_status_wr.sv
// Self-checking bench for fpga_status_wr: randomized status frames compared
// cycle by cycle against a frame/timeline model built from the frame rules.
module tb_fpga_status_wr;

  localparam logic [9:0] BASE = 10'h100;
  localparam int         NW   = 16;
  localparam int         IW   = 20;

  logic         clk_100M = 1'b0;
  logic         reset_n;
  logic         start;
  logic [223:0] stat_data;
  logic [9:0]   addr_w;
  logic [15:0]  ram_din;
  logic         ram_we;
  logic         fpga_w;
  logic         XINT_FPGA;
  logic         busy;
  logic         done;
  logic         ovr;
  logic [15:0]  frame_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] cnt_m   = 16'h0000;

  fpga_status_wr dut (
    .clk_100M  (clk_100M),
    .reset_n   (reset_n),
    .start     (start),
    .stat_data (stat_data),
    .addr_w    (addr_w),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .fpga_w    (fpga_w),
    .XINT_FPGA (XINT_FPGA),
    .busy      (busy),
    .done      (done),
    .ovr       (ovr),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [223:0] rand_data();
    logic [223:0] d;
    for (int k = 0; k < 14; k++) d[16*k +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " we"}, ram_we, 0);
    check({tag, " addr"}, addr_w, BASE);
    check({tag, " din"}, ram_din, 0);
    check({tag, " fpga_w"}, fpga_w, 0);
    check({tag, " xint"}, XINT_FPGA, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " ovr"}, ovr, 0);
    check({tag, " cnt"}, frame_cnt, 0);
  endtask

  // One frame: start, then NW writes, IW interrupt cycles, done.
  // mut_c: cycle to scramble stat_data; s1/s2: cycles to raise start again;
  // rst_c: cycle to pull reset_n low (abandons the frame). -1 disables each.
  task automatic run_frame(input logic [223:0] d, input int mut_c, input int s1,
                           input int s2, input int rst_c);
    logic [15:0] w[NW];
    logic [15:0] sum;
    logic        ovr_e;
    bit          in_w, in_i;
    w[0] = cnt_m;
    sum  = cnt_m;
    for (int k = 1; k <= 14; k++) begin
      w[k] = d[16*(k-1) +: 16];
      sum  = sum + w[k];
    end
    w[NW-1] = ~sum;

    @(negedge clk_100M);
    check("pre busy", busy, 0);
    start     = 1'b1;
    stat_data = d;
    @(negedge clk_100M);
    start = 1'b0;
    ovr_e = 1'b0;
    for (int c = 0; c <= NW + IW; c++) begin
      in_w = (c < NW);
      in_i = (c >= NW) && (c < NW + IW);
      check($sformatf("we c%0d", c), ram_we, in_w);
      check($sformatf("addr c%0d", c), addr_w, in_w ? 32'(BASE) + c : 32'(BASE));
      check($sformatf("din c%0d", c), ram_din, in_w ? w[c] : 16'h0);
      check($sformatf("fpga_w c%0d", c), fpga_w, in_w);
      check($sformatf("xint c%0d", c), XINT_FPGA, !in_i);
      check($sformatf("busy c%0d", c), busy, c < NW + IW);
      check($sformatf("done c%0d", c), done, c == NW + IW);
      check($sformatf("ovr c%0d", c), ovr, ovr_e);
      check($sformatf("cnt c%0d", c), frame_cnt,
            (c == NW + IW) ? 16'(cnt_m + 16'd1) : cnt_m);
      if (c == rst_c) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int r = 0; r < 4; r++) begin
          @(negedge clk_100M);
          check($sformatf("rst hold xint %0d", r), XINT_FPGA, 1);
          check($sformatf("rst hold done %0d", r), done, 0);
          check($sformatf("rst hold we %0d", r), ram_we, 0);
        end
        reset_n = 1'b1;
        start   = 1'b0;
        cnt_m   = 16'h0000;
        for (int r = 0; r < 30; r++) begin
          @(negedge clk_100M);
          check($sformatf("post rst xint %0d", r), XINT_FPGA, 1);
          check($sformatf("post rst done %0d", r), done, 0);
        end
        return;
      end
      ovr_e = (c == s1) || (c == s2);
      start = ovr_e;
      if (c == mut_c) stat_data = ~stat_data ^ 224'($urandom);
      if (c < NW + IW) @(negedge clk_100M);
    end
    start = 1'b0;
    cnt_m = cnt_m + 16'd1;
  endtask

  initial begin
    reset_n   = 1'b1;
    start     = 1'b0;
    stat_data = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk_100M);
    reset_n = 1'b1;

    // All status words 0x0001: checksum 0xFFF1, counter word 0
    run_frame({14{16'h0001}}, -1, -1, -1, -1);
    // Back-to-back start the cycle after done; inputs scrambled mid-frame
    run_frame(rand_data(), 2, -1, -1, -1);
    // Rejected starts: 5 cycles in, and in the final interrupt cycle
    run_frame(rand_data(), -1, 4, NW + IW - 1, -1);
    run_frame(rand_data(), -1, -1, -1, -1);
    // Reset while word 0x107 is on the bus
    run_frame(rand_data(), -1, -1, -1, 7);
    run_frame(rand_data(), -1, -1, -1, -1);

    // Counter wrap from 0xFFFF
    @(negedge clk_100M);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    cnt_m = 16'hFFFF;
    check("preload cnt", frame_cnt, 16'hFFFF);
    run_frame(rand_data(), -1, -1, -1, -1);
    check("wrap cnt", frame_cnt, 16'h0000);

    for (int i = 0; i < 3; i++) run_frame(rand_data(), -1, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
